status_sequencer: RTL and testbench



---
 rtl/status_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_status_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/status_sequencer.sv
// status_sequencer
//   READY / ERROR / FAULT state machine that feeds the single-digit status
//   decoder on the DE10-Lite and drives the error-count and fault LEDs.
//
// Ports
//   clk_i      : system clock (50 MHz)
//   rst_i      : synchronous, active-high reset
//   err_i      : error event line, synchronous; each rising edge is one event
//   ack_ni     : raw acknowledge key, active-low, asynchronous
//   status_o   : {heartbeat, code}; code 2'b11 = r, 2'b01 = E, 2'b00 = F
//   err_cnt_o  : total error events, saturating at 15
//   fault_o    : high while in FAULT
//
// Build option
//   STATUS_SEQ_DEBOUNCE_EN : when defined, the synchronised key must hold a
//   new level for DEB_CYCLES consecutive cycles before it is accepted.
module status_sequencer #(
  parameter int unsigned DEB_CYCLES   = 50000,
  parameter int unsigned ERR_LIMIT    = 3,
  parameter int unsigned HOLD_CYCLES  = 50000000,
  parameter int unsigned BLINK_CYCLES = 25000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       err_i,
  input  logic       ack_ni,
  output logic [2:0] status_o,
  output logic [3:0] err_cnt_o,
  output logic       fault_o
);

  // Elaboration-time guard on the parameter ranges the design relies on.
  if (ERR_LIMIT < 1 || ERR_LIMIT > 15 || DEB_CYCLES < 1 || HOLD_CYCLES < 1 ||
      BLINK_CYCLES < 1) begin : g_bad_param
    $error("status_sequencer: parameter out of range");
  end

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

  // Encodings double as the decoder code on status_o[1:0].
  typedef enum logic [1:0] {
    ST_FAULT = 2'b00,
    ST_ERROR = 2'b01,
    ST_READY = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            ack_dly_q, ack_dly_d;
  logic            err_dly_q, err_dly_d;
  logic [3:0]      err_cnt_q, err_cnt_d;
  logic [3:0]      strike_q, strike_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;

  logic            ack_sync;
  logic            ack_clean;
  logic            press;
  logic            err_edge;
  logic [3:0]      strike_inc;

  assign ack_sync = ~sync2_q;

`ifdef STATUS_SEQ_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

  logic          ack_clean_q, ack_clean_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;

  // Any cycle where ack_sync agrees with the accepted level restarts the count.
  always_comb begin
    ack_clean_d = ack_clean_q;
    deb_cnt_d   = '0;
    if (ack_sync != ack_clean_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        ack_clean_d = ack_sync;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_clean_q <= 1'b0;
      deb_cnt_q   <= '0;
    end else begin
      ack_clean_q <= ack_clean_d;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  assign ack_clean = ack_clean_q;
`else
  assign ack_clean = ack_sync;
`endif

  assign press      = ack_clean & ~ack_dly_q;
  assign err_edge   = err_i & ~err_dly_q;
  assign strike_inc = strike_q + 4'd1;

  always_comb begin
    sync1_d     = ack_ni;
    sync2_d     = sync1_q;
    ack_dly_d   = ack_clean;
    err_dly_d   = err_i;
    err_cnt_d   = err_cnt_q;
    strike_d    = strike_q;
    state_d     = state_q;
    hold_d      = '0;
    blink_cnt_d = '0;
    blink_d     = 1'b0;

    if (err_edge && err_cnt_q != 4'hF) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end

    unique case (state_q)
      ST_READY: begin
        if (err_edge) begin
          strike_d = strike_inc;
          state_d  = (strike_inc >= 4'(ERR_LIMIT)) ? ST_FAULT : ST_ERROR;
        end
      end
      ST_ERROR: begin
        // An error in the same cycle as a press wins; the press is dropped.
        if (err_edge) begin
          strike_d = strike_inc;
          state_d  = (strike_inc >= 4'(ERR_LIMIT)) ? ST_FAULT : ST_ERROR;
        end else if (press) begin
          state_d = ST_READY;
        end
      end
      ST_FAULT: begin
        blink_d = blink_q;
        if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
          blink_d = ~blink_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
        end
        if (ack_clean) begin
          if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            state_d     = ST_READY;
            strike_d    = '0;
            blink_d     = 1'b0;
            blink_cnt_d = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_READY;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      ack_dly_q   <= 1'b0;
      err_dly_q   <= 1'b0;
      err_cnt_q   <= '0;
      strike_q    <= '0;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      ack_dly_q   <= ack_dly_d;
      err_dly_q   <= err_dly_d;
      err_cnt_q   <= err_cnt_d;
      strike_q    <= strike_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign status_o  = {blink_q, state_q};
  assign err_cnt_o = err_cnt_q;
  assign fault_o   = (state_q == ST_FAULT);

endmodule

// File: tb/tb_status_sequencer.sv
// Directed bench for status_sequencer with small timing parameters.
module tb_status_sequencer;

  localparam int unsigned DEB   = 4;
  localparam int unsigned LIM   = 3;
  localparam int unsigned HOLD  = 10;
  localparam int unsigned BLINK = 5;

`ifdef STATUS_SEQ_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif
  // ack_clean changes after edge k+CLEAN_LAT when the key is first sampled
  // at edge k; the resulting state change lands one edge later.
  localparam int CLEAN_LAT = DEB_ON ? int'(DEB) + 1 : 1;
  localparam int KEY_LAT   = CLEAN_LAT + 1;

  localparam logic [1:0] S_R = 2'b11;
  localparam logic [1:0] S_E = 2'b01;
  localparam logic [1:0] S_F = 2'b00;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       err_i;
  logic       ack_ni;
  logic [2:0] status_o;
  logic [3:0] err_cnt_o;
  logic       fault_o;

  status_sequencer #(
    .DEB_CYCLES  (DEB),
    .ERR_LIMIT   (LIM),
    .HOLD_CYCLES (HOLD),
    .BLINK_CYCLES(BLINK)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .err_i    (err_i),
    .ack_ni   (ack_ni),
    .status_o (status_o),
    .err_cnt_o(err_cnt_o),
    .fault_o  (fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic       err;
    logic       ack_n;
    logic [1:0] st;
    logic [3:0] cnt;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  int         fe    = 0;       // edges spent in FAULT since entry
  logic [1:0] prev_st = S_R;

  // Drive inputs, take one edge, compare #1 later. The heartbeat bit is
  // predicted from the number of edges the expected state has been FAULT.
  task automatic cyc(input logic rst, input logic err, input logic ackn,
                     input logic [1:0] st, input logic [3:0] cnt,
                     input string nm);
    logic [2:0] exp_s;
    logic       exp_f;
    rst_i  = rst;
    err_i  = err;
    ack_ni = ackn;
    @(posedge clk_i);
    #1;
    if (st == S_F) fe = (prev_st == S_F) ? fe + 1 : 0;
    else           fe = 0;
    prev_st = st;
    exp_s = {(st == S_F) && (((fe / int'(BLINK)) % 2) == 1), st};
    exp_f = (st == S_F);
    tests++;
    if (status_o !== exp_s || err_cnt_o !== cnt || fault_o !== exp_f) begin
      fails++;
      $display("FAIL %s: got status=%b cnt=%0d fault=%b, expected status=%b cnt=%0d fault=%b",
               nm, status_o, err_cnt_o, fault_o, exp_s, cnt, exp_f);
    end
  endtask

  vec_t vecs[23];

  initial begin
    rst_i  = 1'b1;
    err_i  = 1'b0;
    ack_ni = 1'b1;

    // Reset, 20 idle cycles, one error pulse.
    vecs[0] = '{rst: 1'b1, err: 1'b0, ack_n: 1'b1, st: S_R, cnt: 4'd0};
    for (int i = 1; i <= 20; i++)
      vecs[i] = '{rst: 1'b0, err: 1'b0, ack_n: 1'b1, st: S_R, cnt: 4'd0};
    vecs[21] = '{rst: 1'b0, err: 1'b1, ack_n: 1'b1, st: S_E, cnt: 4'd1};
    vecs[22] = '{rst: 1'b0, err: 1'b0, ack_n: 1'b1, st: S_E, cnt: 4'd1};
    for (int i = 0; i < 23; i++)
      cyc(vecs[i].rst, vecs[i].err, vecs[i].ack_n, vecs[i].st, vecs[i].cnt, "table");

    // Ack held low 8 cycles returns ERROR -> READY KEY_LAT edges after first sample.
    for (int i = 1; i <= 8; i++)
      cyc(1'b0, 1'b0, 1'b0, (i > KEY_LAT) ? S_R : S_E, 4'd1, "ack_return");
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 1'b1, S_R, 4'd1, "ack_release");

    // Second and third strikes -> FAULT, then blink and further events.
    cyc(1'b0, 1'b1, 1'b1, S_E, 4'd2, "err2");
    cyc(1'b0, 1'b0, 1'b1, S_E, 4'd2, "err2_low");
    cyc(1'b0, 1'b1, 1'b1, S_F, 4'd3, "fault_entry");
    for (int i = 1; i <= 12; i++) begin
      int c;
      c = 3 + int'(i >= 2) + int'(i >= 4) + int'(i >= 6);
      cyc(1'b0, (i == 2 || i == 4 || i == 6), 1'b1, S_F, 4'(c), "fault_blink_cnt");
    end

    // Short press must not clear FAULT; release clears hold progress.
    for (int i = 1; i <= 7; i++) cyc(1'b0, 1'b0, 1'b0, S_F, 4'd6, "short_press");
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 1'b1, S_F, 4'd6, "short_release");
    // Long press: READY HOLD edges after ack_clean rises.
    for (int i = 1; i <= 20; i++)
      cyc(1'b0, 1'b0, 1'b0, (i > CLEAN_LAT + int'(HOLD)) ? S_R : S_F, 4'd6, "long_press");
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 1'b1, S_R, 4'd6, "long_release");
    cyc(1'b0, 1'b1, 1'b1, S_E, 4'd7, "strikes_reset");
    cyc(1'b0, 1'b0, 1'b1, S_E, 4'd7, "strikes_reset_low");

    // Error edge coincides with press in ERROR: error wins.
    for (int i = 1; i <= KEY_LAT + 2; i++)
      cyc(1'b0, (i == KEY_LAT + 1), 1'b0, S_E, (i > KEY_LAT) ? 4'd8 : 4'd7, "err_vs_press");
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 1'b1, S_E, 4'd8, "coincide_release");

    // Two-cycle key glitch: ignored with debounce, a press without.
    cyc(1'b0, 1'b0, 1'b0, S_E, 4'd8, "glitch");
    cyc(1'b0, 1'b0, 1'b0, S_E, 4'd8, "glitch");
    for (int i = 1; i <= 8; i++)
      cyc(1'b0, 1'b0, 1'b1, DEB_ON ? S_E : S_R, 4'd8, "glitch_after");
    // Strikes are 2 here in both builds, so one more event forces FAULT.
    cyc(1'b0, 1'b1, 1'b1, S_F, 4'd9, "strikes_two");
    cyc(1'b0, 1'b0, 1'b1, S_F, 4'd9, "strikes_two_low");

    // Saturate the error counter in FAULT.
    for (int j = 1; j <= 7; j++) begin
      logic [3:0] c;
      c = (9 + j > 15) ? 4'd15 : 4'(9 + j);
      cyc(1'b0, 1'b1, 1'b1, S_F, c, "saturate");
      cyc(1'b0, 1'b0, 1'b1, S_F, c, "saturate_low");
    end

    // Reset partway through the hold.
    for (int i = 1; i <= CLEAN_LAT + 4; i++)
      cyc(1'b0, 1'b0, 1'b0, S_F, 4'd15, "mid_hold");
    cyc(1'b1, 1'b0, 1'b0, S_R, 4'd0, "reset_mid_hold");
    for (int i = 1; i <= 14; i++) cyc(1'b0, 1'b0, 1'b0, S_R, 4'd0, "post_reset_hold");
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 1'b1, S_R, 4'd0, "post_reset_release");
    cyc(1'b0, 1'b1, 1'b1, S_E, 4'd1, "post_reset_err");
    cyc(1'b0, 1'b0, 1'b1, S_E, 4'd1, "post_reset_err_low");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
